uart_tx_arbiter: RTL and testbench
==================================

// Module: uart_tx_arbiter
// PURPOSE
//  Shares one UART transmitter (start/done handshake, 8N1 framing) between
//  NUM_REQ byte producers using round-robin arbitration. Latches the winner's
//  byte, launches the transmitter, and waits for its frame-complete pulse.
//  Acks the requester and recovers from a hung transmitter via a watchdog.
//  Sits between client logic (e.g. RX echo, status reporter) and the UART TX.
// PARAMETERS
//  NUM_REQ        4     number of requesters (2..8)
//  DATA_WIDTH     8     byte width presented to the transmitter
//  WDOG_WIDTH     16    watchdog counter width
//  WDOG_TOP       5000  clk cycles in WAIT before timeout (> one 10-bit frame)
// PORTS
//  clk          in   1                    system clock, rising edge
//  rstn         in   1                    asynchronous, active-low reset
//  req          in   NUM_REQ              per-requester byte request, level
//  req_data     in   NUM_REQ*DATA_WIDTH   requester i byte at [i*DW +: DW]
//  req_ack      out  NUM_REQ              1-cycle pulse: requester's byte done
//  tx_start     out  1                    1-cycle pulse to UART TX: send tx_data
//  tx_data      out  DATA_WIDTH           byte to send, stable from start to done
//  tx_done      in   1                    1-cycle pulse from TX: frame finished
//  grant_id     out  $clog2(NUM_REQ)      index of current/last granted requester
//  busy         out  1                    high in any state other than IDLE
//  wdog_err     out  1                    1-cycle pulse: watchdog expired
// BEHAVIOUR
//  Reset (rstn low, async): state=IDLE, tx_start=0, tx_data=0, req_ack=0,
//   grant_id=NUM_REQ-1 (so requester 0 has first priority), busy=0,
//   wdog_err=0, watchdog=0. All outputs are registered.
//  FSM: IDLE -> LAUNCH -> WAIT -> DONE -> IDLE.
//   IDLE: if |req, pick the first set req scanning grant_id+1, +2, ... with
//    wrap mod NUM_REQ. Latch grant_id and tx_data=req_data[winner] -> LAUNCH.
//    If no req is set, stay in IDLE.
//   LAUNCH: tx_start=1 for exactly this cycle; clear watchdog -> WAIT.
//   WAIT: watchdog increments each cycle. On tx_done -> DONE.
//    When watchdog reaches WDOG_TOP-1 with no tx_done: wdog_err=1 -> DONE.
//    If tx_done and expiry coincide, tx_done wins and wdog_err stays 0.
//   DONE: req_ack[grant_id]=1 for this cycle (also after a timeout) -> IDLE.
//  Latency: req sampled in IDLE at edge N; tx_start high during cycle N+1.
//   After tx_done at edge M, ack is high during cycle M+1, and IDLE arbitrates
//   again at cycle M+2. Throughput is one byte per frame plus 3 cycles.
//  Requester contract: hold req and req_data stable until req_ack.
//   Drop req, or change req_data for the next byte, on the edge closing the
//   ack cycle. A req still high in the following cycle is a new request.
//  Data is captured at grant: a req deasserted after grant is still sent and
//   still acked. req changes during LAUNCH/WAIT/DONE are ignored.
//  tx_done seen outside WAIT is ignored. tx_data holds its value until the
//   next grant.
//  Fairness: a requester that holds req continuously waits at most NUM_REQ-1
//   other frames.
//  Reset mid-frame: returns to IDLE immediately and issues no ack. The
//   external TX has its own reset.
// STRUCTURE
//  uart_pkg: arb_state_t enum {IDLE, LAUNCH, WAIT, DONE}, plus shared baud/frame
//   constants already used by the UART counter.
//  Sub-module uart_rr_picker (combinational): inputs req and last grant; outputs
//   found and winner index. It is reused by the planned RX-side FIFO arbiter.
// TESTING
//  T1 reset: rstn=0 mid-WAIT -> busy=0, tx_start=0, req_ack=0, grant_id=3.
//   No ack is issued after release.
//  T2 single: req=4'b0100, data2=8'hA5 -> tx_start pulse at cycle+1 with
//   tx_data=A5. BFM tx_done 20 cycles later -> req_ack=4'b0100 next cycle.
//  T3 round-robin: req=4'b1111 held; each requester re-raises after ack ->
//   grant order 0,1,2,3,0. Each ack is one-hot and matches grant_id.
//  T4 watchdog: WDOG_TOP=50, no tx_done -> wdog_err pulse at WAIT cycle 50,
//   then req_ack, then the next requester is served.
//  T5 edge races: tx_done in the same cycle as watchdog expiry -> wdog_err=0.
//   Spurious tx_done in IDLE -> no state change. req dropped after grant ->
//   byte still sent and acked.
//  T6 stream: 16 random bytes from random requesters against a UART TX model
//   -> scoreboard shows no loss or duplication; fairness bound is held.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: arbiter state encoding, frame timing constants
// and the round-robin index helper used by the requester pickers.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        WAIT   = 2'd2,
        DONE   = 2'd3
    } arb_state_t;

    localparam int UART_CLK_HZ       = 50_000_000;
    localparam int UART_BAUD         = 115_200;
    localparam int UART_CLKS_PER_BIT = UART_CLK_HZ / UART_BAUD;
    localparam int UART_FRAME_BITS   = 10;
    localparam int UART_FRAME_CLKS   = UART_CLKS_PER_BIT * UART_FRAME_BITS;

    // Position reached by stepping 'offset' places past 'base' on a ring of n.
    function automatic int rr_index(input int base, input int offset, input int n);
        return (base + offset) % n;
    endfunction

endpackage

// File: rtl/uart_rr_picker.sv
// Combinational round-robin picker: first set request strictly after the
// last grant, wrapping; the last grant itself has lowest priority.
module uart_rr_picker
    import uart_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IW      = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IW-1:0]      last_i,
    output logic               found_o,
    output logic [IW-1:0]      winner_o
);

    logic [IW-1:0] idx;

    always_comb begin
        found_o  = 1'b0;
        winner_o = last_i;
        idx      = '0;
        for (int off = 1; off <= NUM_REQ; off++) begin
            idx = IW'(rr_index(int'(last_i), off, NUM_REQ));
            if (!found_o && req_i[idx]) begin
                found_o  = 1'b1;
                winner_o = idx;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin sharing of one UART transmitter between NUM_REQ byte producers,
// with a watchdog that abandons a frame whose done pulse never arrives.
//
//   state  | meaning
//   IDLE   | arbitrate among pending requests, latch winner and its byte
//   LAUNCH | tx_start pulse to the transmitter, watchdog cleared
//   WAIT   | frame in flight; exit on tx_done or watchdog expiry
//   DONE   | ack pulse to the granted requester (also after a timeout)
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int WDOG_WIDTH = 16,
    parameter int WDOG_TOP   = 5000
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ack,
    output logic                          tx_start,
    output logic [DATA_WIDTH-1:0]         tx_data,
    input  logic                          tx_done,
    output logic [$clog2(NUM_REQ)-1:0]    grant_id,
    output logic                          busy,
    output logic                          wdog_err
);

    localparam int                    IW        = $clog2(NUM_REQ);
    localparam logic [WDOG_WIDTH-1:0] WDOG_LAST = WDOG_WIDTH'(WDOG_TOP - 1);
    localparam logic [IW-1:0]         GRANT_RST = IW'(NUM_REQ - 1);
    localparam logic [NUM_REQ-1:0]    ACK_ONE   = {{(NUM_REQ-1){1'b0}}, 1'b1};

    arb_state_t              state_q;
    logic [IW-1:0]           grant_q;
    logic [DATA_WIDTH-1:0]   data_q;
    logic                    start_q;
    logic [NUM_REQ-1:0]      ack_q;
    logic                    busy_q;
    logic                    wdog_err_q;
    logic [WDOG_WIDTH-1:0]   wdog_q;
    logic [WDOG_WIDTH-1:0]   wdog_d;
    logic [NUM_REQ-1:0]      ack_d;

    logic                    pick_found;
    logic [IW-1:0]           pick_idx;
    logic [DATA_WIDTH-1:0]   pick_data;

    uart_rr_picker #(
        .NUM_REQ (NUM_REQ),
        .IW      (IW)
    ) u_picker (
        .req_i    (req),
        .last_i   (grant_q),
        .found_o  (pick_found),
        .winner_o (pick_idx)
    );

    always_comb begin
        pick_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick_idx == IW'(i)) begin
                pick_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign wdog_d = wdog_q + 1'b1;
    assign ack_d  = ACK_ONE << grant_q;

    // Pulse outputs default low every cycle; each state raises only its own.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= IDLE;
            grant_q    <= GRANT_RST;
            data_q     <= '0;
            start_q    <= 1'b0;
            ack_q      <= '0;
            busy_q     <= 1'b0;
            wdog_err_q <= 1'b0;
            wdog_q     <= '0;
        end else begin
            start_q    <= 1'b0;
            ack_q      <= '0;
            wdog_err_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (pick_found) begin
                        grant_q <= pick_idx;
                        data_q  <= pick_data;
                        start_q <= 1'b1;
                        busy_q  <= 1'b1;
                        state_q <= LAUNCH;
                    end
                end
                LAUNCH: begin
                    wdog_q  <= '0;
                    state_q <= WAIT;
                end
                WAIT: begin
                    // tx_done is tested first so a coincident expiry never flags an error.
                    if (tx_done) begin
                        ack_q   <= ack_d;
                        state_q <= DONE;
                    end else if (wdog_q == WDOG_LAST) begin
                        ack_q      <= ack_d;
                        wdog_err_q <= 1'b1;
                        state_q    <= DONE;
                    end else begin
                        wdog_q <= wdog_d;
                    end
                end
                DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign req_ack  = ack_q;
    assign tx_start = start_q;
    assign tx_data  = data_q;
    assign grant_id = grant_q;
    assign busy     = busy_q;
    assign wdog_err = wdog_err_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: requesters, a UART TX model and a
// cycle-level reference of arbitration order, latency and watchdog timing.
module tb_uart_tx_arbiter;

    localparam int N   = 4;
    localparam int DW  = 8;
    localparam int WDT = 50;

    logic            clk;
    logic            rstn;
    logic [N-1:0]    req;
    logic [N*DW-1:0] req_data;
    logic [N-1:0]    req_ack;
    logic            tx_start;
    logic [DW-1:0]   tx_data;
    logic            tx_done;
    logic            tx_done_model;
    logic            tx_done_spur;
    logic [1:0]      grant_id;
    logic            busy;
    logic            wdog_err;

    assign tx_done = tx_done_model | tx_done_spur;

    uart_tx_arbiter #(
        .NUM_REQ    (N),
        .DATA_WIDTH (DW),
        .WDOG_WIDTH (16),
        .WDOG_TOP   (WDT)
    ) dut (
        .clk      (clk),
        .rstn     (rstn),
        .req      (req),
        .req_data (req_data),
        .req_ack  (req_ack),
        .tx_start (tx_start),
        .tx_data  (tx_data),
        .tx_done  (tx_done),
        .grant_id (grant_id),
        .busy     (busy),
        .wdog_err (wdog_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        int         id;
        logic [7:0] data;
    } sb_item_t;

    int         checks   = 0;
    int         failures = 0;
    sb_item_t   sb[$];
    int         grant_log[$];
    int         ack_cnt  = 0;
    int         wdog_cnt = 0;
    logic [N-1:0] ack_last = '0;
    int         tx_delay_q[$];
    int         tx_default = -1;
    int         remaining[N];

    // reference-model state
    int         cyc       = 0;
    bit         in_frame  = 0;
    bit         resolved  = 0;
    bit         exp_err   = 0;
    bit         prev_idle = 1;
    int         start_cyc = 0;
    int         ack_due   = -1;
    int         exp_last  = N - 1;
    logic [N-1:0] req_prev = '0;
    logic [7:0] cur_byte  = '0;
    int         wait_frames[N];

    task automatic chk_eq(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_le(input string name, input int act, input int lim);
        checks++;
        if (act > lim) begin
            failures++;
            $display("FAIL %s: got %0d expected at most %0d (t=%0t)", name, act, lim, $time);
        end
    endtask

    task automatic timeout_fail(input string name, input int budget);
        checks++;
        failures++;
        $display("FAIL %s: no completion, expected within %0d cycles (t=%0t)", name, budget, $time);
    endtask

    // First pending requester after 'last' in ascending order, else the lowest one.
    function automatic int rr_expect(input logic [N-1:0] pending, input int last);
        for (int j = last + 1; j < N; j++) if (pending[j]) return j;
        for (int j = 0; j <= last; j++) if (pending[j]) return j;
        return -1;
    endfunction

    task automatic monitor_step();
        bit           exp_start;
        bit           covered;
        int           w;
        int           hit;
        logic [N-1:0] exp_ack;
        cyc++;
        if (!rstn) begin
            in_frame  = 0;
            resolved  = 0;
            prev_idle = 1;
            req_prev  = '0;
            exp_last  = N - 1;
            ack_last  = '0;
            for (int i = 0; i < N; i++) wait_frames[i] = 0;
            return;
        end
        exp_start = prev_idle && (req_prev != '0);
        chk_eq("tx_start", int'(tx_start), int'(exp_start));
        if (tx_start && exp_start) begin
            w = rr_expect(req_prev, exp_last);
            chk_eq("grant_id", int'(grant_id), w);
            hit = -1;
            foreach (sb[k]) if (hit < 0 && sb[k].id == w) hit = k;
            chk_eq("sb_has_byte", int'(hit >= 0), 1);
            if (hit >= 0) begin
                cur_byte = sb[hit].data;
                chk_eq("tx_data", int'(tx_data), int'(cur_byte));
                sb.delete(hit);
            end
            for (int i = 0; i < N; i++) begin
                if (i == w) wait_frames[i] = 0;
                else if (req_prev[i]) begin
                    wait_frames[i]++;
                    chk_le("fairness", wait_frames[i], N - 1);
                end
            end
            exp_last  = w;
            in_frame  = 1;
            start_cyc = cyc;
            resolved  = 0;
            ack_due   = -1;
            grant_log.push_back(w);
        end else if (in_frame && !resolved && cyc > start_cyc) begin
            if (tx_done) begin
                ack_due  = cyc + 1;
                exp_err  = 0;
                resolved = 1;
            end else if (cyc == start_cyc + WDT) begin
                ack_due  = cyc + 1;
                exp_err  = 1;
                resolved = 1;
            end
        end
        exp_ack = '0;
        if (in_frame && cyc == ack_due) exp_ack[exp_last] = 1'b1;
        chk_eq("req_ack", int'(req_ack), int'(exp_ack));
        chk_eq("wdog_err", int'(wdog_err), int'(exp_ack != '0 && exp_err));
        chk_eq("busy", int'(busy), int'(in_frame));
        if (in_frame) chk_eq("tx_data_stable", int'(tx_data), int'(cur_byte));
        covered = in_frame;
        if (in_frame && cyc == ack_due) begin
            ack_cnt++;
            if (exp_err) wdog_cnt++;
            in_frame = 0;
        end
        prev_idle = !covered;
        req_prev  = req;
        ack_last  = req_ack;
    endtask

    initial begin
        forever begin
            @(negedge clk);
            monitor_step();
        end
    end

    // UART TX model: done pulse d cycles after the start cycle; d == 0 hangs.
    initial begin
        int d;
        tx_done_model = 1'b0;
        forever begin
            @(negedge clk);
            if (rstn && tx_start) begin
                if (tx_delay_q.size() > 0) d = tx_delay_q.pop_front();
                else if (tx_default < 0) d = int'($urandom_range(10, 30));
                else d = tx_default;
                if (d > 0) begin
                    repeat (d) @(posedge clk);
                    #1;
                    if (rstn) tx_done_model = 1'b1;
                    @(posedge clk);
                    #1 tx_done_model = 1'b0;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic give_byte(input int i, input int fixed_byte);
        logic [7:0] b;
        b = (fixed_byte >= 0) ? 8'(fixed_byte) : 8'($urandom_range(0, 255));
        req_data[i*DW +: DW] = b;
        req[i] = 1'b1;
        sb.push_back('{i, b});
    endtask

    task automatic serve(input logic [N-1:0] mask, input int fixed_byte, input int budget);
        int t;
        for (int i = 0; i < N; i++) if (mask[i]) give_byte(i, fixed_byte);
        t = 0;
        while (req != '0) begin
            tick();
            for (int i = 0; i < N; i++) if (ack_last[i]) req[i] = 1'b0;
            t++;
            if (t >= budget) begin
                timeout_fail("serve", budget);
                req = '0;
            end
        end
    endtask

    task automatic run_stream(input bit hold, input int budget);
        int t;
        int left;
        t = 0;
        forever begin
            tick();
            for (int i = 0; i < N; i++) begin
                if (ack_last[i]) begin
                    if (remaining[i] > 0 && (hold || $urandom_range(0, 1) == 1)) begin
                        give_byte(i, -1);
                        remaining[i]--;
                    end else begin
                        req[i] = 1'b0;
                    end
                end else if (!req[i] && remaining[i] > 0 && (hold || $urandom_range(0, 3) == 0)) begin
                    give_byte(i, -1);
                    remaining[i]--;
                end
            end
            left = 0;
            for (int i = 0; i < N; i++) left += remaining[i];
            if (left == 0 && req == '0 && !in_frame) break;
            t++;
            if (t >= budget) begin
                timeout_fail("stream", budget);
                req = '0;
                break;
            end
        end
    endtask

    initial begin
        #400_000;
        $display("FAIL global_timeout: simulation did not finish, expected completion before %0t", $time);
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "global timeout");
    end

    initial begin
        int a0;
        int w0;
        int t;
        rstn         = 1'b0;
        req          = '0;
        req_data     = '0;
        tx_done_spur = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_eq("rst_busy", int'(busy), 0);
        chk_eq("rst_tx_start", int'(tx_start), 0);
        chk_eq("rst_req_ack", int'(req_ack), 0);
        chk_eq("rst_grant_id", int'(grant_id), N - 1);
        chk_eq("rst_wdog_err", int'(wdog_err), 0);
        chk_eq("rst_tx_data", int'(tx_data), 0);
        rstn = 1'b1;
        repeat (2) tick();

        // round-robin with every requester holding req
        grant_log.delete();
        remaining = '{2, 1, 1, 1};
        run_stream(1'b1, 1000);
        chk_eq("rr_count", grant_log.size(), 5);
        for (int k = 0; k < grant_log.size() && k < 5; k++) chk_eq("rr_order", grant_log[k], k % N);

        // single request, fixed byte, 20-cycle frame
        grant_log.delete();
        a0 = ack_cnt;
        tx_delay_q.push_back(20);
        serve(4'b0100, 'hA5, 200);
        chk_eq("single_acks", ack_cnt - a0, 1);
        chk_eq("single_grant", (grant_log.size() > 0) ? grant_log[0] : -1, 2);
        repeat (5) tick();
        chk_eq("single_data_hold", int'(tx_data), 'hA5);
        chk_eq("single_idle", int'(busy), 0);

        // watchdog: first frame hangs, next requester still served
        grant_log.delete();
        a0 = ack_cnt;
        w0 = wdog_cnt;
        tx_delay_q.push_back(0);
        tx_default = 15;
        serve(4'b1001, -1, 400);
        chk_eq("wdog_pulses", wdog_cnt - w0, 1);
        chk_eq("wdog_acks", ack_cnt - a0, 2);
        chk_eq("wdog_order0", (grant_log.size() > 0) ? grant_log[0] : -1, 3);
        chk_eq("wdog_order1", (grant_log.size() > 1) ? grant_log[1] : -1, 0);

        // tx_done coincident with watchdog expiry
        a0 = ack_cnt;
        w0 = wdog_cnt;
        tx_delay_q.push_back(WDT);
        serve(4'b0010, -1, 300);
        chk_eq("race_wdog", wdog_cnt - w0, 0);
        chk_eq("race_acks", ack_cnt - a0, 1);

        // spurious tx_done while idle
        a0 = ack_cnt;
        tick();
        tx_done_spur = 1'b1;
        tick();
        tx_done_spur = 1'b0;
        repeat (4) tick();
        chk_eq("spur_busy", int'(busy), 0);
        chk_eq("spur_acks", ack_cnt - a0, 0);

        // req dropped during LAUNCH: byte still sent and acked
        grant_log.delete();
        a0 = ack_cnt;
        give_byte(3, -1);
        tick();
        req[3] = 1'b0;
        for (t = 0; t < 200 && ack_cnt == a0; t++) tick();
        chk_eq("drop_acks", ack_cnt - a0, 1);
        chk_eq("drop_grant", (grant_log.size() > 0) ? grant_log[0] : -1, 3);

        // reset in the middle of WAIT
        a0 = ack_cnt;
        tx_delay_q.push_back(0);
        give_byte(1, -1);
        for (t = 0; t < 20 && !in_frame; t++) tick();
        chk_eq("rst_mid_started", int'(in_frame), 1);
        repeat (10) tick();
        #2 rstn = 1'b0;
        #1;
        chk_eq("rst_mid_busy", int'(busy), 0);
        chk_eq("rst_mid_tx_start", int'(tx_start), 0);
        chk_eq("rst_mid_req_ack", int'(req_ack), 0);
        chk_eq("rst_mid_grant_id", int'(grant_id), N - 1);
        req = '0;
        repeat (3) tick();
        rstn = 1'b1;
        repeat (70) tick();
        chk_eq("rst_mid_no_ack", ack_cnt - a0, 0);
        chk_eq("rst_mid_idle", int'(busy), 0);

        // random stream of 16 bytes
        tx_delay_q.delete();
        tx_default = -1;
        a0 = ack_cnt;
        remaining = '{0, 0, 0, 0};
        for (int k = 0; k < 16; k++) remaining[$urandom_range(0, N - 1)]++;
        run_stream(1'b0, 6000);
        repeat (5) tick();
        chk_eq("stream_acks", ack_cnt - a0, 16);
        chk_eq("stream_sb_empty", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
